// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-initiator CPU-to-APB bridge with one-hot address decode and PREADY timeout
module apb_master_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PENABLE,
  output logic [4:0]  PSEL,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic [31:0] PRDATA4,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3,
  input  logic        PREADY4
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERROR} state_t;
  state_t state, state_next;
  logic [CW-1:0] cnt;
  logic [4:0] sel, dec, pready;
  logic [31:0] prdata;
  logic hit, sel_ready, tmo, ack, done;
  assign hit = addr[31:11] == 21'h020000 && addr[10:8] < 3'd5;
  assign dec = hit ? 5'b00001 << addr[10:8] : 5'b0;
  assign pready = {PREADY4, PREADY3, PREADY2, PREADY1, PREADY0};
  assign prdata = ({32{sel[0]}} & PRDATA0) | ({32{sel[1]}} & PRDATA1) | ({32{sel[2]}} & PRDATA2) |
                  ({32{sel[3]}} & PRDATA3) | ({32{sel[4]}} & PRDATA4);
  assign sel_ready = |(pready & sel);
  assign tmo = cnt == CW'(TIMEOUT - 1);
  // PREADY takes priority over a coincident terminal count
  assign ack = state == ACCESS && sel_ready;
  assign done = state == ERROR || (state == ACCESS && (sel_ready || tmo));
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state == IDLE   ? (transfer ? (hit ? SETUP : ERROR) : IDLE) :
                 state == SETUP  ? ACCESS :
                 state == ACCESS ? (done ? IDLE : ACCESS) : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    PENABLE = state == ACCESS;
    PSEL = (state == SETUP || state == ACCESS) ? sel : 5'b0;
  end
  always_ff @(posedge PCLK or negedge PRESET)
    if (!PRESET) begin
      PADDR <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      sel <= '0;
      cnt <= '0;
      ready <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= done;
      if (state == IDLE && transfer) begin
        PADDR <= addr;
        PWRITE <= write;
        PWDATA <= wdata;
        sel <= dec;
      end
      if (state == SETUP) cnt <= '0;
      else if (state == ACCESS && !done) cnt <= cnt + CW'(1);
      if (done) begin
        err <= !ack;
        rdata <= (ack && !PWRITE) ? prdata : 32'h0;
      end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized bench with programmable-wait APB slaves and a latency/result reference model
module tb_apb_master_bridge;
  localparam int TO = 16;
  localparam int NEVER = 99;
  logic PCLK = 0, PRESET = 0, transfer = 0, write = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] rdata, PADDR, PWDATA;
  logic ready, err, busy, PWRITE, PENABLE;
  logic [4:0] PSEL, prdy, noise = 0;
  logic [31:0] prd [5];
  int wcfg [5];
  int acc [5];
  int checks = 0, errors = 0;
  logic last_err = 0;
  logic [31:0] last_rd = 0;

  apb_master_bridge #(.TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA0(prd[0]), .PRDATA1(prd[1]), .PRDATA2(prd[2]), .PRDATA3(prd[3]), .PRDATA4(prd[4]),
    .PREADY0(prdy[0]), .PREADY1(prdy[1]), .PREADY2(prdy[2]), .PREADY3(prdy[3]), .PREADY4(prdy[4])
  );

  always #5 PCLK = ~PCLK;

  // slave k raises PREADY after wcfg[k] wait cycles in ACCESS; unselected slaves drive random noise
  always_comb
    for (int k = 0; k < 5; k++) prdy[k] = PSEL[k] ? (PENABLE && acc[k] >= wcfg[k]) : noise[k];
  always @(posedge PCLK or negedge PRESET)
    if (!PRESET) for (int k = 0; k < 5; k++) acc[k] <= 0;
    else for (int k = 0; k < 5; k++) acc[k] <= (PSEL[k] && PENABLE && !prdy[k]) ? acc[k] + 1 : 0;
  always @(negedge PCLK) noise = 5'($urandom);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // called #1 after a clock edge with the bridge idle; returns #1 after the completion edge
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [31:0] rd);
    bit mapped;
    int k, lat, c;
    logic eerr;
    logic [31:0] erd;
    logic [4:0] oh;
    mapped = (a >> 8) >= 32'h100000 && (a >> 8) <= 32'h100004;
    k = mapped ? int'((a >> 8) - 32'h100000) : 0;
    oh = mapped ? 5'(1 << k) : 5'b0;
    for (int j = 0; j < 5; j++) prd[j] = $urandom;
    prd[k] = rd;
    if (!mapped) begin lat = 2; eerr = 1; erd = 0; end
    else if (wcfg[k] < TO) begin lat = 3 + wcfg[k]; eerr = 0; erd = w ? 32'h0 : rd; end
    else begin lat = 2 + TO; eerr = 1; erd = 0; end
    addr = a; write = w; wdata = d; transfer = 1;
    c = 0;
    do begin
      @(posedge PCLK); #1; c++;
      if (!ready && c < 60) begin
        check("busy", 32'(busy), 1);
        check("paddr", PADDR, a);
        check("pwrite", 32'(PWRITE), 32'(w));
        check("pwdata", PWDATA, d);
        check("psel", 32'(PSEL), 32'(oh));
        if (mapped) check("penable", 32'(PENABLE), 32'(c >= 2));
        transfer = 1'($urandom); addr = $urandom; write = 1'($urandom); wdata = $urandom;
      end
    end while (!ready && c < 60);
    transfer = 0; addr = a;
    check("latency", 32'(c), 32'(lat));
    check("ready", 32'(ready), 1);
    check("err", 32'(err), 32'(eerr));
    check("rdata", rdata, erd);
    check("psel_end", 32'(PSEL), 0);
    check("penable_end", 32'(PENABLE), 0);
    last_err = eerr; last_rd = erd;
  endtask

  task automatic idle_check();
    @(posedge PCLK); #1;
    check("ready_pulse", 32'(ready), 0);
    check("err_hold", 32'(err), 32'(last_err));
    check("rdata_hold", rdata, last_rd);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    logic [31:0] a;
    int picks [7] = '{0, 1, 2, 5, TO - 1, TO, NEVER};
    for (int k = 0; k < 5; k++) begin wcfg[k] = 0; prd[k] = 0; end
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_ready", 32'(ready), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rdata", rdata, 0);
    check("rst_psel", 32'(PSEL), 0);
    check("rst_paddr", PADDR, 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge PCLK) PRESET = 1;
    @(posedge PCLK); #1;
    run_txn(32'h1000_0100, 1, 32'h0000_00A5, $urandom);
    idle_check();
    wcfg[2] = 1;
    run_txn(32'h1000_0204, 0, $urandom, 32'h0000_003C);
    idle_check();
    run_txn(32'h2000_0000, 0, $urandom, $urandom);
    idle_check();
    wcfg[4] = NEVER;
    run_txn(32'h1000_0400, 0, $urandom, $urandom);
    run_txn(32'h1000_0000, 0, $urandom, $urandom);
    run_txn(32'h1000_0008, 1, $urandom, $urandom);
    idle_check();
    wcfg[1] = TO - 1;
    run_txn(32'h1000_01FC, 0, $urandom, 32'h1234_5678);
    wcfg[1] = TO;
    run_txn(32'h1000_01FC, 0, $urandom, 32'h1234_5678);
    idle_check();
    for (int i = 0; i < 40; i++) begin
      int k = int'($urandom_range(0, 4));
      wcfg[k] = picks[$urandom_range(0, 6)];
      a = ($urandom_range(0, 4) == 0) ? ($urandom | 32'h2000_0000) : (32'h1000_0000 + 32'(k << 8) + ($urandom & 32'hFF));
      run_txn(a, 1'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    wcfg[3] = NEVER;
    addr = 32'h1000_0300; write = 0; transfer = 1;
    @(posedge PCLK); #1 transfer = 0;
    repeat (3) @(posedge PCLK);
    #1;
    check("pre_rst_penable", 32'(PENABLE), 1);
    PRESET = 0;
    #1;
    check("arst_psel", 32'(PSEL), 0);
    check("arst_penable", 32'(PENABLE), 0);
    check("arst_ready", 32'(ready), 0);
    check("arst_busy", 32'(busy), 0);
    @(negedge PCLK) PRESET = 1;
    last_err = 0; last_rd = 0;
    idle_check();
    wcfg[3] = 2;
    run_txn(32'h1000_0310, 0, $urandom, 32'hCAFE_F00D);
    idle_check();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
